// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ALU operation, forwards operands from EX/MEM and MEM/WB,
// and inserts a one-cycle bubble on a load-use hazard.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     id_rs_data,
  input  logic [DATA_WIDTH-1:0]     id_rt_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [5:0]                id_funct,
  input  logic [1:0]                id_aluOp,
  input  logic                      id_aluSrc,
  input  logic                      id_regDst,
  input  logic                      id_regWrite,
  input  logic                      id_memRead,
  input  logic                      id_memWrite,
  input  logic                      id_memToReg,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      exmem_regWrite,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_regWrite,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     alu_data1,
  output logic [DATA_WIDTH-1:0]     alu_data2,
  output logic [3:0]                alu_operation,
  output logic [REG_ADDR_WIDTH-1:0] ex_dest,
  output logic [DATA_WIDTH-1:0]     ex_storeData,
  output logic                      ex_regWrite,
  output logic                      ex_memRead,
  output logic                      ex_memWrite,
  output logic                      ex_memToReg,
  output logic                      hazard_stall
);

  logic [DATA_WIDTH-1:0]     rs_data_q, rt_data_q, imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rt_q, dest_q;
  logic                      alu_src_q;
  logic [3:0]                op_q;
  logic                      reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic [3:0]                op_next;
  logic [DATA_WIDTH-1:0]     fwd_rs, fwd_rt;

  always_comb begin
    op_next = 4'b0010;
    case (id_aluOp)
      2'b00: op_next = 4'b0010;
      2'b01: op_next = 4'b0110;
      2'b11: op_next = 4'b0001;
      default: begin
        case (id_funct)
          6'b100000: op_next = 4'b0010;
          6'b100010: op_next = 4'b0110;
          6'b100100: op_next = 4'b0000;
          6'b100101: op_next = 4'b0001;
          6'b100111: op_next = 4'b1100;
          6'b101010: op_next = 4'b0111;
          default:   op_next = 4'b1111;
        endcase
      end
    endcase
  end

  // Load in EX whose target is read by the instruction in ID; suppressed while held or squashed.
  assign hazard_stall = mem_read_q && (dest_q != '0) &&
                        ((dest_q == id_rs) || (dest_q == id_rt)) && !stall && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && hazard_stall)) begin
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      alu_src_q    <= 1'b0;
      op_q         <= 4'b0000;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (!stall) begin
      rs_data_q    <= id_rs_data;
      rt_data_q    <= id_rt_data;
      imm_q        <= id_imm;
      rs_q         <= id_rs;
      rt_q         <= id_rt;
      dest_q       <= id_regDst ? id_rd : id_rt;
      alu_src_q    <= id_aluSrc;
      op_q         <= op_next;
      reg_write_q  <= id_regWrite;
      mem_read_q   <= id_memRead;
      mem_write_q  <= id_memWrite;
      mem_to_reg_q <= id_memToReg;
    end
  end

  // EX/MEM is the younger result, so it takes precedence over MEM/WB.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_regWrite && (exmem_rd != '0) && (exmem_rd == rs_q))
      fwd_rs = exmem_result;
    else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == rs_q))
      fwd_rs = memwb_result;

    fwd_rt = rt_data_q;
    if (exmem_regWrite && (exmem_rd != '0) && (exmem_rd == rt_q))
      fwd_rt = exmem_result;
    else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == rt_q))
      fwd_rt = memwb_result;
  end

  assign alu_data1     = fwd_rs;
  assign alu_data2     = alu_src_q ? imm_q : fwd_rt;
  assign ex_storeData  = fwd_rt;
  assign alu_operation = op_q;
  assign ex_dest       = dest_q;
  assign ex_regWrite   = reg_write_q;
  assign ex_memRead    = mem_read_q;
  assign ex_memWrite   = mem_write_q;
  assign ex_memToReg   = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding, load-use bubble, stall/flush/reset priority.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_aluOp;
  logic        id_aluSrc, id_regDst, id_regWrite, id_memRead, id_memWrite, id_memToReg;
  logic        stall, flush;
  logic        exmem_regWrite, memwb_regWrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_data1, alu_data2, ex_storeData;
  logic [3:0]  alu_operation;
  logic [4:0]  ex_dest;
  logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, hazard_stall;

  int errors = 0;
  int checks = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_aluOp(id_aluOp),
    .id_aluSrc(id_aluSrc), .id_regDst(id_regDst), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_memToReg(id_memToReg),
    .stall(stall), .flush(flush),
    .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_operation(alu_operation),
    .ex_dest(ex_dest), .ex_storeData(ex_storeData),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memToReg(ex_memToReg), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_funct = '0; id_aluOp = '0;
    id_aluSrc = 0; id_regDst = 0; id_regWrite = 0;
    id_memRead = 0; id_memWrite = 0; id_memToReg = 0;
  endtask

  task automatic clear_fwd();
    exmem_regWrite = 0; exmem_rd = '0; exmem_result = '0;
    memwb_regWrite = 0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
    clear_id();
    id_rs = rs; id_rt = rt; id_rd = rd; id_funct = funct; id_aluOp = 2'b10;
    id_rs_data = a; id_rt_data = b; id_regDst = 1; id_regWrite = 1;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    clear_id(); clear_fwd();
    // Reset state, with valid-looking ID inputs present
    rtype(5'd1, 5'd2, 5'd3, 6'b100000, 32'h1234, 32'h5678);
    tick(); tick();
    chk("reset_data1", alu_data1, 32'h0);
    chk("reset_data2", alu_data2, 32'h0);
    chk("reset_op", 32'(alu_operation), 32'h0);
    chk("reset_ctrl", {27'd0, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, hazard_stall}, 32'h0);
    chk("reset_dest", 32'(ex_dest), 32'h0);
    reset = 0;

    // R-type AND
    rtype(5'd1, 5'd2, 5'd3, 6'b100100, 32'hF0F0, 32'h0FF0);
    tick();
    chk("and_op", 32'(alu_operation), 32'h0);
    chk("and_data1", alu_data1, 32'hF0F0);
    chk("and_data2", alu_data2, 32'h0FF0);
    chk("and_dest", 32'(ex_dest), 32'd3);
    chk("and_regwrite", 32'(ex_regWrite), 32'd1);

    // lw r8 followed by a consumer of r8
    clear_id();
    id_aluOp = 2'b00; id_aluSrc = 1; id_memRead = 1; id_memToReg = 1; id_regWrite = 1;
    id_rs = 5'd1; id_rt = 5'd8; id_rd = 5'd31; id_imm = 32'h10; id_rs_data = 32'h100;
    tick();
    chk("lw_memread", 32'(ex_memRead), 32'd1);
    chk("lw_dest", 32'(ex_dest), 32'd8);
    chk("lw_data2_imm", alu_data2, 32'h10);
    chk("lw_op", 32'(alu_operation), 32'h2);
    rtype(5'd8, 5'd2, 5'd4, 6'b100000, 32'hAAAA, 32'h2222);
    #1;
    chk("hazard_asserted", 32'(hazard_stall), 32'd1);
    stall = 1; #1;
    chk("hazard_gated_by_stall", 32'(hazard_stall), 32'd0);
    stall = 0; flush = 1; #1;
    chk("hazard_gated_by_flush", 32'(hazard_stall), 32'd0);
    flush = 0; #1;
    tick();
    chk("bubble_regwrite", 32'(ex_regWrite), 32'd0);
    chk("bubble_memread", 32'(ex_memRead), 32'd0);
    chk("bubble_dest", 32'(ex_dest), 32'd0);
    chk("bubble_op", 32'(alu_operation), 32'h0);
    chk("hazard_dropped", 32'(hazard_stall), 32'd0);
    tick();
    chk("held_dest", 32'(ex_dest), 32'd4);
    chk("held_data1", alu_data1, 32'hAAAA);
    chk("held_regwrite", 32'(ex_regWrite), 32'd1);

    // Forwarding priority
    rtype(5'd5, 5'd6, 5'd7, 6'b100000, 32'h55, 32'h66);
    tick();
    exmem_regWrite = 1; exmem_rd = 5'd5; exmem_result = 32'h11;
    memwb_regWrite = 1; memwb_rd = 5'd5; memwb_result = 32'h22;
    #1;
    chk("fwd_exmem_wins", alu_data1, 32'h11);
    chk("fwd_rt_untouched", alu_data2, 32'h66);
    exmem_regWrite = 0; #1;
    chk("fwd_memwb", alu_data1, 32'h22);
    memwb_rd = 5'd6; #1;
    chk("fwd_memwb_rt", ex_storeData, 32'h22);
    rtype(5'd0, 5'd6, 5'd7, 6'b100000, 32'h77, 32'h66);
    exmem_regWrite = 1; exmem_rd = 5'd0; memwb_regWrite = 1; memwb_rd = 5'd0;
    tick();
    chk("no_fwd_r0", alu_data1, 32'h77);
    clear_fwd();

    // SUB captured, then stall for 3 cycles while ID changes
    clear_id();
    id_aluOp = 2'b01; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd9;
    id_rs_data = 32'hA; id_rt_data = 32'hB; id_regWrite = 1;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rtype(5'(i + 10), 5'd12, 5'd13, 6'b100111, 32'(i + 100), 32'h9);
      tick();
      chk("stall_op", 32'(alu_operation), 32'h6);
      chk("stall_data1", alu_data1, 32'hA);
      chk("stall_dest", 32'(ex_dest), 32'd2);
    end
    flush = 1;
    tick();
    chk("flush_op", 32'(alu_operation), 32'h0);
    chk("flush_regwrite", 32'(ex_regWrite), 32'd0);
    chk("flush_dest", 32'(ex_dest), 32'd0);
    chk("flush_data1", alu_data1, 32'h0);
    stall = 0; flush = 0;

    // OR captured, then reset mid-stream
    clear_id();
    id_aluOp = 2'b11; id_rs = 5'd3; id_rt = 5'd4; id_rs_data = 32'h5; id_regWrite = 1;
    tick();
    chk("or_op", 32'(alu_operation), 32'h1);
    chk("or_regwrite", 32'(ex_regWrite), 32'd1);
    reset = 1; stall = 1;
    tick();
    chk("midreset_regwrite", 32'(ex_regWrite), 32'd0);
    chk("midreset_op", 32'(alu_operation), 32'h0);
    chk("midreset_data1", alu_data1, 32'h0);
    reset = 0; stall = 0;

    // Remaining funct decodes
    rtype(5'd1, 5'd2, 5'd3, 6'b111111, 32'h1, 32'h2);
    tick();
    chk("unknown_funct", 32'(alu_operation), 32'hF);
    rtype(5'd1, 5'd2, 5'd3, 6'b100111, 32'h1, 32'h2);
    tick();
    chk("nor_op", 32'(alu_operation), 32'hC);
    rtype(5'd1, 5'd2, 5'd3, 6'b101010, 32'h1, 32'h2);
    tick();
    chk("slt_op", 32'(alu_operation), 32'h7);
    rtype(5'd1, 5'd2, 5'd3, 6'b100101, 32'h1, 32'h2);
    tick();
    chk("or_funct_op", 32'(alu_operation), 32'h1);
    rtype(5'd1, 5'd2, 5'd3, 6'b100010, 32'h1, 32'h2);
    tick();
    chk("sub_funct_op", 32'(alu_operation), 32'h6);

    // sw with store data forwarded from MEM/WB
    clear_id();
    id_aluOp = 2'b00; id_aluSrc = 1; id_memWrite = 1; id_imm = 32'd4;
    id_rs = 5'd1; id_rt = 5'd9; id_rs_data = 32'h1000; id_rt_data = 32'h1;
    tick();
    memwb_regWrite = 1; memwb_rd = 5'd9; memwb_result = 32'hABCD;
    #1;
    chk("sw_storedata", ex_storeData, 32'hABCD);
    chk("sw_data2", alu_data2, 32'd4);
    chk("sw_op", 32'(alu_operation), 32'h2);
    chk("sw_memwrite", 32'(ex_memWrite), 32'd1);
    chk("sw_dest", 32'(ex_dest), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
